// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// IDLE accepts an op, CALC runs 32 shift-add / restoring-divide steps on
// operand magnitudes, DONE pulses `done` for one cycle. Divide-by-zero and
// signed overflow resolve on the accepting edge.
// Optional build macro MULDIV_FAST_MUL_EN: all multiplies complete on the
// accepting edge through a single wide multiplier (divide path unchanged).
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_addr_out
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          rd_q, rd_d;
  logic [4:0]          rd_out_q, rd_out_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc_q, acc_d;        // {hi, lo} working register
  logic [4:0]          cnt_q, cnt_d;
  logic                neg_q, neg_d;        // product / quotient negate
  logic                rneg_q, rneg_d;      // remainder negate (dividend sign)
  logic [XLEN-1:0]     result_q, result_d;
  logic                done_q, done_d;

  // operand decode for the request presented in IDLE
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            spec_hit;
  logic [XLEN-1:0] spec_res;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fa, fb, fprod;
`endif

  // sign handling: which operands are signed for this op and their magnitudes
  always_comb begin
    a_sgn = funct3[2] ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
    b_sgn = funct3[2] ? ~funct3[0] : (funct3 == 3'b001);
    a_neg = a_sgn & rs1_data[XLEN-1];
    b_neg = b_sgn & rs2_data[XLEN-1];
    a_mag = a_neg ? -rs1_data : rs1_data;
    b_mag = b_neg ? -rs2_data : rs2_data;
  end

  // ops that finish on the accepting edge and their results
  always_comb begin
    spec_hit = 1'b0;
    spec_res = '0;
`ifdef MULDIV_FAST_MUL_EN
    fa    = a_sgn ? {{XLEN{rs1_data[XLEN-1]}}, rs1_data} : {{XLEN{1'b0}}, rs1_data};
    fb    = b_sgn ? {{XLEN{rs2_data[XLEN-1]}}, rs2_data} : {{XLEN{1'b0}}, rs2_data};
    fprod = fa * fb;
`endif
    if (funct3[2] && rs2_data == '0) begin
      spec_hit = 1'b1;
      spec_res = funct3[1] ? rs1_data : '1;
    end else if (funct3[2] && !funct3[0] &&
                 rs1_data == {1'b1, {(XLEN-1){1'b0}}} && rs2_data == '1) begin
      spec_hit = 1'b1;
      spec_res = funct3[1] ? '0 : rs1_data;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!funct3[2]) begin
      spec_hit = 1'b1;
      spec_res = (funct3 == 3'b000) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
    end
`endif
  end

  // one iteration step and the sign-corrected final result
  logic [XLEN:0]     mul_sum, div_r, div_t;
  logic [2*XLEN-1:0] mul_next, div_next, step_next, prod;
  logic [XLEN-1:0]   quot, rem, fin_res;

  always_comb begin
    // shift-add: add multiplicand into hi when lo[0] set, then shift right
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    // restoring divide: shift dividend bit into remainder, trial subtract
    div_r    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_t    = div_r - {1'b0, opnd_q};
    div_next = div_t[XLEN] ? {div_r[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                           : {div_t[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step_next = op_q[2] ? div_next : mul_next;
    prod = neg_q  ? -step_next : step_next;
    quot = neg_q  ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
    rem  = rneg_q ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 fin_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = quot;
      default:                fin_res = rem;
    endcase
  end

  // control FSM next-state: accept, iterate, pulse done; flush aborts
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!flush && start) begin
          op_d   = funct3;
          rd_d   = rd_addr_in;
          cnt_d  = '0;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (funct3[2]) begin
            opnd_d = b_mag;
            acc_d  = {{XLEN{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {{XLEN{1'b0}}, b_mag};
          end
          if (spec_hit) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = spec_res;
            rd_out_d = rd_addr_in;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = fin_res;
            rd_out_d = rd_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign result      = result_q;
  assign rd_addr_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed + randomized checks of muldiv_unit against an
// arithmetic reference model; a negedge monitor checks busy, done, result,
// rd_addr_out and latency of every accepted op.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_addr_out;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr_in(rd_addr_in),
    .flush(flush), .busy(busy), .done(done), .result(result),
    .rd_addr_out(rd_addr_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          e0;
    int          lat;
  } exp_t;
  exp_t q[$];

  logic [31:0] prev_res;
  logic [4:0]  prev_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  // reference model: RV32M semantics in plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    logic [63:0] p;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (f3)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin x = sa; y = sb; p = x * y; return p[63:32]; end
      3'd2: begin x = sa; y = {32'd0, b}; p = x * y; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if (f3 == 3'd4 || f3 == 3'd6)
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f3[2]) return 1;
`endif
    return 33;
  endfunction

  // compare process: busy tracks outstanding ops, each done matches the model
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("rd_addr_out", {27'd0, rd_addr_out}, {27'd0, e.rd});
          chk("latency", cyc - e.e0 + 1, e.lat);
        end
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (busy && g < 100) begin @(negedge clk); g++; end
    if (busy) timeout("wait_idle");
  endtask

  task automatic wait_drain();
    int g = 0;
    while (q.size() != 0 && g < 100) begin @(negedge clk); #1; g++; end
    if (q.size() != 0) begin timeout("wait_done"); q.delete(); end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] expv);
    exp_t e;
    funct3 = f3; rs1_data = a; rs2_data = b; rd_addr_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e.res = expv; e.rd = rd; e.e0 = cyc; e.lat = exp_lat(f3, a, b);
    q.push_back(e);
    prev_res = expv; prev_rd = rd;
  endtask

  // literal expectation, hand-computed
  task automatic run_lit(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] lit);
    wait_idle();
    issue(f3, a, b, rd, lit);
    wait_drain();
  endtask

  task automatic run_mdl(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    wait_idle();
    issue(f3, a, b, rd, model(f3, a, b));
    wait_drain();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int g;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0;
    rs1_data = '0; rs2_data = '0; rd_addr_in = '0;
    prev_res = '0; prev_rd = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", {27'd0, rd_addr_out}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // directed cases with literal results
    run_lit(3'd4, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD);
    run_lit(3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF);
    run_lit(3'd5, 32'hDEADBEEF, 32'd0, 5'd7, 32'hFFFFFFFF);
    run_lit(3'd7, 32'h00001234, 32'd0, 5'd8, 32'h00001234);
    run_lit(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd9, 32'h80000000);
    run_lit(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h00000000);
    run_lit(3'd1, 32'h80000000, 32'h80000000, 5'd11, 32'h40000000);
    run_lit(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'hFFFFFFFE);
    run_lit(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFF);
    run_lit(3'd0, 32'd7, 32'hFFFFFFFD, 5'd14, 32'hFFFFFFEB);

    // flush at E10 of a DIVU: no done, outputs hold
    wait_idle();
    issue(3'd5, 32'd1000, 32'd3, 5'd20, 32'd333);
    prev_res = 32'hFFFFFFEB; prev_rd = 5'd14;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; q.delete();
    @(negedge clk);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_result", result, prev_res);
    chk("flush_rd", {27'd0, rd_addr_out}, {27'd0, prev_rd});
    repeat (40) @(negedge clk);

    // flush and start together in IDLE: nothing accepted
    funct3 = 3'd5; rs1_data = 32'd9; rs2_data = 32'd0; rd_addr_in = 5'd21;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    chk("flush_start_done", {31'd0, done}, 32'd0);
    repeat (5) @(negedge clk);

    // start during CALC and during DONE is ignored; right after is accepted
    wait_idle();
    issue(3'd4, 32'hFFFFFF9C, 32'd9, 5'd3, model(3'd4, 32'hFFFFFF9C, 32'd9));
    repeat (4) @(negedge clk);
    funct3 = 3'd5; rs1_data = 32'd5; rs2_data = 32'd0; rd_addr_in = 5'd30; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    g = 0;
    do begin @(negedge clk); g++; end while (!done && g < 60);
    if (!done) timeout("handshake_done");
    funct3 = 3'd0; rs1_data = 32'd3; rs2_data = 32'd4; rd_addr_in = 5'd31; start = 1'b1;
    @(posedge clk); #1;
    issue(3'd7, 32'd50, 32'd7, 5'd12, 32'd1);
    wait_drain();

    // async reset in the middle of a DIV
    wait_idle();
    issue(3'd4, 32'd1000, 32'd13, 5'd4, model(3'd4, 32'd1000, 32'd13));
    repeat (15) @(posedge clk);
    #2; rst_n = 1'b0; q.delete();
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_rd", {27'd0, rd_addr_out}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_lit(3'd4, 32'd100, 32'd7, 5'd2, 32'd14);

    // randomized ops against the model
    for (int i = 0; i < 150; i++)
      run_mdl(3'($urandom % 8), pick(), pick(), 5'($urandom % 32));

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
